// File: rtl/cfg_pkg.sv
// Build-time configuration shared by the stack address-decode pipeline.
package cfg_pkg;

    localparam int ENGS_N = 4;

endpackage : cfg_pkg

// File: rtl/stk_pkg.sv
// Common types for the stack pipeline: engine id width and engine id type.
package stk_pkg;

    import cfg_pkg::*;

    localparam int ENGID_W = (ENGS_N > 1) ? $clog2(ENGS_N) : 1;

    typedef logic [ENGID_W-1:0] engid_t;

endpackage : stk_pkg

// File: rtl/stk_rr_arb.sv
// Combinational round-robin arbiter: searches the request vector starting at
// the supplied pointer and returns a one-hot grant plus the pointer to use
// after that grant. The pointer register itself lives in the parent.
module stk_rr_arb #(
    parameter int W     = 4,
    parameter int PTR_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [W-1:0]     gnt,
    output logic [PTR_W-1:0] nxt_ptr
);

    logic [PTR_W:0]   idx_ext;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Walk the requesters from ptr upward with explicit wrap so non-power-of-two W works.
    always_comb begin
        gnt     = '0;
        nxt_ptr = ptr;
        found   = 1'b0;
        idx_ext = '0;
        idx     = '0;
        for (int i = 0; i < W; i++) begin
            idx_ext = {1'b0, ptr} + (PTR_W+1)'(i);
            if (idx_ext >= (PTR_W+1)'(W)) begin
                idx_ext = idx_ext - (PTR_W+1)'(W);
            end
            idx = idx_ext[PTR_W-1:0];
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                if (idx == PTR_W'(W - 1)) begin
                    nxt_ptr = '0;
                end else begin
                    nxt_ptr = idx + PTR_W'(1);
                end
            end
        end
    end

endmodule : stk_rr_arb

// File: rtl/stk_pipe_ad_iss.sv
// Issue stage of the stack address-decode pipeline: picks the invalidation
// request or one eligible engine command per cycle and loads it into a
// registered slot, while tracking which engines are currently active.
module stk_pipe_ad_iss
    import stk_pkg::*;
#(
    parameter int ENGS_N  = cfg_pkg::ENGS_N,
    parameter int ENGID_W = stk_pkg::ENGID_W
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               i_inv_req,
    input  logic [ENGID_W-1:0] i_inv_engid,
    output logic               o_inv_ack,
    input  logic [ENGS_N-1:0]  i_eng_req,
    output logic [ENGS_N-1:0]  o_eng_ack,
    input  logic [ENGS_N-1:0]  i_active_set_d,
    input  logic [ENGS_N-1:0]  i_active_clr_d,
    output logic [ENGS_N-1:0]  o_active_r,
    input  logic               i_pipe_stall,
    output logic               o_pipe_vld_r,
    output logic [ENGID_W-1:0] o_pipe_engid_r,
    output logic               o_pipe_isinv_r
);

    logic [ENGS_N-1:0]  active_r;
    logic [ENGID_W-1:0] rr_ptr_r;
    logic [ENGID_W-1:0] arb_nxt_ptr;
    logic [ENGS_N-1:0]  eng_elig;
    logic [ENGS_N-1:0]  eng_gnt;
    logic [ENGID_W-1:0] gnt_id;
    logic               can_iss;
    logic               eng_en;
    logic               eng_any;

    // A same-cycle set pulse already blocks the engine; invalidation always outranks engines.
    always_comb begin
        can_iss   = ~o_pipe_vld_r | ~i_pipe_stall;
        eng_elig  = i_eng_req & ~active_r & ~i_active_set_d;
        o_inv_ack = arst_n & can_iss & i_inv_req;
        eng_en    = arst_n & can_iss & ~i_inv_req;
    end

    stk_rr_arb #(
        .W     (ENGS_N),
        .PTR_W (ENGID_W)
    ) u_rr_arb (
        .req     (eng_elig),
        .ptr     (rr_ptr_r),
        .en      (eng_en),
        .gnt     (eng_gnt),
        .nxt_ptr (arb_nxt_ptr)
    );

    // Turn the one-hot engine grant into the engine id written into the slot.
    always_comb begin
        gnt_id = '0;
        for (int k = 0; k < ENGS_N; k++) begin
            if (eng_gnt[k]) begin
                gnt_id = gnt_id | ENGID_W'(k);
            end
        end
    end

    assign eng_any    = |eng_gnt;
    assign o_eng_ack  = eng_gnt;
    assign o_active_r = active_r;

    // Active vector, round-robin pointer and pipeline slot; set beats clear on the same bit.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            active_r       <= '0;
            rr_ptr_r       <= '0;
            o_pipe_vld_r   <= 1'b0;
            o_pipe_engid_r <= '0;
            o_pipe_isinv_r <= 1'b0;
        end else begin
            active_r <= (active_r & ~i_active_clr_d) | i_active_set_d;
            if (eng_any) begin
                rr_ptr_r <= arb_nxt_ptr;
            end
            if (o_inv_ack) begin
                o_pipe_vld_r   <= 1'b1;
                o_pipe_engid_r <= i_inv_engid;
                o_pipe_isinv_r <= 1'b1;
            end else if (eng_any) begin
                o_pipe_vld_r   <= 1'b1;
                o_pipe_engid_r <= gnt_id;
                o_pipe_isinv_r <= 1'b0;
            end else if (!i_pipe_stall) begin
                o_pipe_vld_r <= 1'b0;
            end
        end
    end

endmodule : stk_pipe_ad_iss

// File: tb/tb_stk_pipe_ad_iss.sv
// Bench for stk_pipe_ad_iss: directed vector table, reset sequences and a
// randomized run against a cycle-level reference model of the issue rules.
module tb_stk_pipe_ad_iss;

    localparam int N = 4;

    logic       clk;
    logic       arst_n;
    logic       i_inv_req;
    logic [1:0] i_inv_engid;
    logic       o_inv_ack;
    logic [3:0] i_eng_req;
    logic [3:0] o_eng_ack;
    logic [3:0] i_active_set_d;
    logic [3:0] i_active_clr_d;
    logic [3:0] o_active_r;
    logic       i_pipe_stall;
    logic       o_pipe_vld_r;
    logic [1:0] o_pipe_engid_r;
    logic       o_pipe_isinv_r;

    int compared;
    int mismatched;

    // sampled combinational acks of the most recent cycle
    logic       s_inv_ack;
    logic [3:0] s_eng_ack;

    // reference model state
    bit m_active[N];
    int m_ptr;
    bit m_vld;
    int m_id;
    bit m_isinv;

    typedef struct {
        logic       inv_req;
        logic [1:0] inv_id;
        logic [3:0] eng_req;
        logic [3:0] set;
        logic [3:0] clr;
        logic       stall;
        logic       exp_inv;
        logic [3:0] exp_eng;
        logic       exp_vld;
        logic [1:0] exp_id;
        logic       exp_isinv;
        logic [3:0] exp_active;
    } vec_t;

    vec_t tbl[18];

    stk_pipe_ad_iss dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .i_inv_req      (i_inv_req),
        .i_inv_engid    (i_inv_engid),
        .o_inv_ack      (o_inv_ack),
        .i_eng_req      (i_eng_req),
        .o_eng_ack      (o_eng_ack),
        .i_active_set_d (i_active_set_d),
        .i_active_clr_d (i_active_clr_d),
        .o_active_r     (o_active_r),
        .i_pipe_stall   (i_pipe_stall),
        .o_pipe_vld_r   (o_pipe_vld_r),
        .o_pipe_engid_r (o_pipe_engid_r),
        .o_pipe_isinv_r (o_pipe_isinv_r)
    );

    // free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] modelActive();
        logic [3:0] v;
        for (int b = 0; b < N; b++) v[b] = m_active[b];
        return v;
    endfunction

    // One clock cycle: drive, sample acks mid-cycle, clock, compare with the model.
    task automatic applyStimulus(input logic rst_n, input logic inv_req, input logic [1:0] inv_id,
                                 input logic [3:0] eng_req, input logic [3:0] set,
                                 input logic [3:0] clr, input logic stall);
        bit         can;
        int         gk;
        logic [3:0] e_eng;
        logic       e_inv;
        arst_n         = rst_n;
        i_inv_req      = inv_req;
        i_inv_engid    = inv_id;
        i_eng_req      = eng_req;
        i_active_set_d = set;
        i_active_clr_d = clr;
        i_pipe_stall   = stall;
        @(negedge clk);
        s_inv_ack = o_inv_ack;
        s_eng_ack = o_eng_ack;

        can   = !m_vld || !stall;
        gk    = -1;
        e_inv = 1'b0;
        e_eng = 4'b0;
        if (rst_n && can) begin
            if (inv_req) begin
                e_inv = 1'b1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_ptr + i) % N;
                    if (eng_req[k] && !m_active[k] && !set[k]) begin
                        gk = k;
                        break;
                    end
                end
                if (gk >= 0) e_eng[gk] = 1'b1;
            end
        end
        checkOutput("model inv_ack", {31'b0, s_inv_ack}, {31'b0, e_inv});
        checkOutput("model eng_ack", {28'b0, s_eng_ack}, {28'b0, e_eng});

        @(posedge clk);
        #1;
        if (!rst_n) begin
            for (int b = 0; b < N; b++) m_active[b] = 1'b0;
            m_ptr = 0; m_vld = 1'b0; m_id = 0; m_isinv = 1'b0;
        end else begin
            for (int b = 0; b < N; b++) begin
                if (set[b])      m_active[b] = 1'b1;
                else if (clr[b]) m_active[b] = 1'b0;
            end
            if (e_inv) begin
                m_vld = 1'b1; m_id = int'(inv_id); m_isinv = 1'b1;
            end else if (gk >= 0) begin
                m_vld = 1'b1; m_id = gk; m_isinv = 1'b0;
                m_ptr = (gk + 1) % N;
            end else if (!stall) begin
                m_vld = 1'b0;
            end
        end
        checkOutput("model vld",    {31'b0, o_pipe_vld_r},   {31'b0, m_vld});
        checkOutput("model engid",  {30'b0, o_pipe_engid_r}, m_id);
        checkOutput("model isinv",  {31'b0, o_pipe_isinv_r}, {31'b0, m_isinv});
        checkOutput("model active", {28'b0, o_active_r},     {28'b0, modelActive()});
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int b = 0; b < N; b++) m_active[b] = 1'b0;
        m_ptr = 0; m_vld = 1'b0; m_id = 0; m_isinv = 1'b0;

        //            inv id eng   set   clr   st | inv eng  vld id isinv active
        tbl[0]  = '{1'b0, 2'd0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0, 1'b0, 4'h0};
        tbl[1]  = '{1'b0, 2'd0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 4'h2, 1'b1, 2'd1, 1'b0, 4'h0};
        tbl[2]  = '{1'b0, 2'd0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 4'h4, 1'b1, 2'd2, 1'b0, 4'h0};
        tbl[3]  = '{1'b0, 2'd0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 4'h8, 1'b1, 2'd3, 1'b0, 4'h0};
        tbl[4]  = '{1'b0, 2'd0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0, 1'b0, 4'h0};
        tbl[5]  = '{1'b1, 2'd2, 4'h2, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 2'd2, 1'b1, 4'h0};
        tbl[6]  = '{1'b0, 2'd0, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0, 4'h2, 1'b1, 2'd1, 1'b0, 4'h0};
        tbl[7]  = '{1'b0, 2'd0, 4'h4, 4'h4, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 1'b0, 4'h4};
        tbl[8]  = '{1'b0, 2'd0, 4'h4, 4'h0, 4'h4, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1, 1'b0, 4'h0};
        tbl[9]  = '{1'b0, 2'd0, 4'h4, 4'h0, 4'h0, 1'b0, 1'b0, 4'h4, 1'b1, 2'd2, 1'b0, 4'h0};
        tbl[10] = '{1'b1, 2'd3, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 2'd2, 1'b0, 4'h0};
        tbl[11] = '{1'b1, 2'd3, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 2'd2, 1'b0, 4'h0};
        tbl[12] = '{1'b1, 2'd3, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 2'd2, 1'b0, 4'h0};
        tbl[13] = '{1'b0, 2'd0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 4'h8, 1'b1, 2'd3, 1'b0, 4'h0};
        tbl[14] = '{1'b0, 2'd0, 4'h0, 4'h8, 4'h8, 1'b0, 1'b0, 4'h0, 1'b0, 2'd3, 1'b0, 4'h8};
        tbl[15] = '{1'b0, 2'd0, 4'h0, 4'h2, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd3, 1'b0, 4'hA};
        tbl[16] = '{1'b0, 2'd0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0, 1'b0, 4'hA};
        tbl[17] = '{1'b1, 2'd3, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 2'd3, 1'b1, 4'hA};

        $display("[TB] reset phase");
        applyStimulus(1'b0, 1'b1, 2'd1, 4'hF, 4'h0, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd1, 4'hF, 4'h0, 4'h0, 1'b0);
        checkOutput("rst inv_ack", {31'b0, s_inv_ack}, 32'd0);
        checkOutput("rst eng_ack", {28'b0, s_eng_ack}, 32'd0);
        checkOutput("rst vld",     {31'b0, o_pipe_vld_r}, 32'd0);
        checkOutput("rst active",  {28'b0, o_active_r},   32'd0);

        $display("[TB] directed vector table");
        for (int r = 0; r < 18; r++) begin
            applyStimulus(1'b1, tbl[r].inv_req, tbl[r].inv_id, tbl[r].eng_req,
                          tbl[r].set, tbl[r].clr, tbl[r].stall);
            checkOutput($sformatf("tbl%0d inv_ack", r), {31'b0, s_inv_ack},      {31'b0, tbl[r].exp_inv});
            checkOutput($sformatf("tbl%0d eng_ack", r), {28'b0, s_eng_ack},      {28'b0, tbl[r].exp_eng});
            checkOutput($sformatf("tbl%0d vld", r),     {31'b0, o_pipe_vld_r},   {31'b0, tbl[r].exp_vld});
            checkOutput($sformatf("tbl%0d engid", r),   {30'b0, o_pipe_engid_r}, {30'b0, tbl[r].exp_id});
            checkOutput($sformatf("tbl%0d isinv", r),   {31'b0, o_pipe_isinv_r}, {31'b0, tbl[r].exp_isinv});
            checkOutput($sformatf("tbl%0d active", r),  {28'b0, o_active_r},     {28'b0, tbl[r].exp_active});
        end

        $display("[TB] reset mid-stall with a loaded slot");
        applyStimulus(1'b0, 1'b1, 2'd2, 4'hF, 4'h0, 4'h0, 1'b1);
        checkOutput("midrst inv_ack", {31'b0, s_inv_ack},      32'd0);
        checkOutput("midrst eng_ack", {28'b0, s_eng_ack},      32'd0);
        checkOutput("midrst vld",     {31'b0, o_pipe_vld_r},   32'd0);
        checkOutput("midrst engid",   {30'b0, o_pipe_engid_r}, 32'd0);
        checkOutput("midrst isinv",   {31'b0, o_pipe_isinv_r}, 32'd0);
        checkOutput("midrst active",  {28'b0, o_active_r},     32'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 4'hF, 4'h0, 4'h0, 1'b0);
        checkOutput("postrst eng_ack", {28'b0, s_eng_ack},      32'h1);
        checkOutput("postrst engid",   {30'b0, o_pipe_engid_r}, 32'd0);
        checkOutput("postrst vld",     {31'b0, o_pipe_vld_r},   32'd1);

        $display("[TB] randomized phase");
        for (int c = 0; c < 400; c++) begin
            logic       rn;
            logic [3:0] st;
            logic [3:0] cl;
            rn = ($urandom_range(0, 63) != 0);
            st = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            cl = ($urandom_range(0, 5) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            applyStimulus(rn, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)), st, cl, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_stk_pipe_ad_iss
